layer_ram_sequencer: RTL and testbench

//  Per-layer compute engine started by the network controller's RAM start pulse.
//  For the selected layer it streams weights and inputs from RAM and forms one signed MAC per neuron.
//  It writes each neuron result to the next layer's input region, then pulses done back to the controller.

---
 rtl/layer_ram_sequencer_pkg.sv | 81 ++++++++
 rtl/layer_ram_sequencer_if.sv | 30 +++
 rtl/layer_ram_sequencer_mac.sv | 72 +++++++
 rtl/layer_ram_sequencer.sv | 120 ++++++++++++
 tb/tb_layer_ram_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/layer_ram_sequencer_pkg.sv
// Shared definitions for the layer RAM sequencer: widths, layer tables,
// FSM encoding and address helpers.
package nn_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef logic [1:0]        layer_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_FIN
  } state_t;

  // One activation write beat (address + result)
  typedef struct packed {
    addr_t addr;
    data_t data;
  } y_wr_t;

  // Inputs per neuron for each layer
  function automatic cnt_t n_in(input layer_t l);
    case (l)
      2'd0:    return CNT_W'(2);
      2'd1:    return CNT_W'(2);
      2'd2:    return CNT_W'(3);
      default: return CNT_W'(2);
    endcase
  endfunction

  // Neurons per layer; layer 3 is empty
  function automatic cnt_t n_out(input layer_t l);
    case (l)
      2'd0:    return CNT_W'(2);
      2'd1:    return CNT_W'(3);
      2'd2:    return CNT_W'(2);
      default: return CNT_W'(0);
    endcase
  endfunction

  // Weight region base per layer
  function automatic addr_t w_base(input layer_t l);
    case (l)
      2'd0:    return ADDR_W'(8'h00);
      2'd1:    return ADDR_W'(8'h10);
      2'd2:    return ADDR_W'(8'h20);
      default: return ADDR_W'(8'h30);
    endcase
  endfunction

  // Activation region base per layer; layer+1 wraps 3 -> 0
  function automatic addr_t x_base(input layer_t l);
    case (l)
      2'd0:    return ADDR_W'(8'h80);
      2'd1:    return ADDR_W'(8'h90);
      2'd2:    return ADDR_W'(8'hA0);
      default: return ADDR_W'(8'hB0);
    endcase
  endfunction

  // Weight address of element i of neuron n
  function automatic addr_t w_addr_f(input layer_t l, input cnt_t n, input cnt_t ni,
                                     input cnt_t i);
    return ADDR_W'(w_base(l) + n * ni + i);
  endfunction

  // Activation read address of element i
  function automatic addr_t x_addr_f(input layer_t l, input cnt_t i);
    return ADDR_W'(x_base(l) + i);
  endfunction

endpackage

// File: rtl/layer_ram_sequencer_if.sv
// Controller / RAM bundle for the layer RAM sequencer.
// master: sequencer side. slave: controller + RAM side.
interface layer_ram_sequencer_if;
  import nn_pkg::*;

  logic   start;
  layer_t layer;
  logic   done;
  logic   busy;
  logic   w_rd;
  addr_t  w_addr;
  data_t  w_data;
  logic   x_rd;
  addr_t  x_addr;
  data_t  x_data;
  logic   y_we;
  addr_t  y_addr;
  data_t  y_data;

  modport master (
    input  start, layer, w_data, x_data,
    output done, busy, w_rd, w_addr, x_rd, x_addr, y_we, y_addr, y_data
  );

  modport slave (
    output start, layer, w_data, x_data,
    input  done, busy, w_rd, w_addr, x_rd, x_addr, y_we, y_addr, y_data
  );

endinterface

// File: rtl/layer_ram_sequencer_mac.sv
// mac_unit: signed Q-format multiply, arithmetic shift, accumulate with
// clear-on-first, and output saturation. RELU_EN clamps negatives to 0.
module mac_unit
  import nn_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_rd,
  input  logic  i_rd_first,
  input  data_t i_w,
  input  data_t i_x,
  output data_t o_y_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  logic                     r_vld;
  logic                     r_first;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [PROD_W-1:0] w_w_s;
  logic signed [PROD_W-1:0] w_x_s;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_prod_sh;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_nxt;

  assign w_w_s      = {{DATA_W{i_w[DATA_W-1]}}, i_w};
  assign w_x_s      = {{DATA_W{i_x[DATA_W-1]}}, i_x};
  assign w_prod     = w_w_s * w_x_s;
  assign w_prod_sh  = w_prod >>> FRAC_W;
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod_sh[PROD_W-1]}}, w_prod_sh};

  // Next accumulator: RAM data is valid the cycle after a read strobe
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_vld) begin
      w_acc_nxt = r_first ? w_prod_ext : r_acc + w_prod_ext;
    end
  end

  // Saturate the next accumulator value so the result can be registered
  // on the same edge that absorbs the last product
  always_comb begin
    o_y_c = w_acc_nxt[DATA_W-1:0];
    if (w_acc_nxt > SAT_MAX) begin
      o_y_c = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (w_acc_nxt < SAT_MIN) begin
      o_y_c = {1'b1, {(DATA_W - 1){1'b0}}};
    end
`ifdef RELU_EN
    if (o_y_c[DATA_W-1]) begin
      o_y_c = '0;
    end
`endif
  end

  // Read-return pipeline and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_vld   <= i_rd;
      r_first <= i_rd_first;
      r_acc   <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/layer_ram_sequencer.sv
// layer_ram_sequencer: per-layer engine. Streams weights/activations for
// each neuron, writes the saturated MAC result to the next layer's input
// region, then pulses done. Optional macro RELU_EN (see mac_unit).
module layer_ram_sequencer
  import nn_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  layer_ram_sequencer_if.master  bus
);

  state_t r_state;
  layer_t r_layer;
  cnt_t   r_n;
  cnt_t   r_i;
  cnt_t   r_ni;
  cnt_t   r_no;
  data_t  w_y_c;
  logic   w_rd_first;

  // r_i indexes the read currently on the bus
  assign w_rd_first = bus.w_rd && (r_i == '0);

  mac_unit u_mac (
    .clk        (clk),
    .rst_n      (reset),
    .i_rd       (bus.w_rd),
    .i_rd_first (w_rd_first),
    .i_w        (bus.w_data),
    .i_x        (bus.x_data),
    .o_y_c      (w_y_c)
  );

  // Sequencing FSM; outputs are registered for the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_layer    <= '0;
      r_n        <= '0;
      r_i        <= '0;
      r_ni       <= '0;
      r_no       <= '0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.w_rd   <= 1'b0;
      bus.w_addr <= '0;
      bus.x_rd   <= 1'b0;
      bus.x_addr <= '0;
      bus.y_we   <= 1'b0;
      bus.y_addr <= '0;
      bus.y_data <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.w_rd <= 1'b0;
      bus.x_rd <= 1'b0;
      bus.y_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_layer  <= bus.layer;
            r_ni     <= n_in(bus.layer);
            r_no     <= n_out(bus.layer);
            r_n      <= '0;
            r_i      <= '0;
            bus.busy <= 1'b1;
            if (n_in(bus.layer) == '0 || n_out(bus.layer) == '0) begin
              r_state  <= ST_FIN;
              bus.done <= 1'b1;
            end else begin
              r_state    <= ST_FETCH;
              bus.w_rd   <= 1'b1;
              bus.x_rd   <= 1'b1;
              bus.w_addr <= w_addr_f(bus.layer, '0, n_in(bus.layer), '0);
              bus.x_addr <= x_addr_f(bus.layer, '0);
            end
          end
        end
        ST_FETCH: begin
          if (r_i == r_ni - CNT_W'(1)) begin
            r_state <= ST_DRAIN;
          end else begin
            r_i        <= r_i + CNT_W'(1);
            bus.w_rd   <= 1'b1;
            bus.x_rd   <= 1'b1;
            bus.w_addr <= w_addr_f(r_layer, r_n, r_ni, r_i + CNT_W'(1));
            bus.x_addr <= x_addr_f(r_layer, r_i + CNT_W'(1));
          end
        end
        ST_DRAIN: begin
          r_state    <= ST_WRITE;
          bus.y_we   <= 1'b1;
          bus.y_addr <= ADDR_W'(x_base(layer_t'(r_layer + 2'd1)) + r_n);
          bus.y_data <= w_y_c;
        end
        ST_WRITE: begin
          r_n <= r_n + CNT_W'(1);
          r_i <= '0;
          if (r_n == r_no - CNT_W'(1)) begin
            r_state  <= ST_FIN;
            bus.done <= 1'b1;
          end else begin
            r_state    <= ST_FETCH;
            bus.w_rd   <= 1'b1;
            bus.x_rd   <= 1'b1;
            bus.w_addr <= w_addr_f(r_layer, r_n + CNT_W'(1), r_ni, '0);
            bus.x_addr <= x_addr_f(r_layer, '0);
          end
        end
        ST_FIN: begin
          r_state  <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_ram_sequencer.sv
// Scoreboard bench for layer_ram_sequencer: directed layers with
// hand-computed results; a negedge monitor checks writes and done timing.
module tb_layer_ram_sequencer;
  import nn_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  y_wr_t exp_wr[$];
  int    exp_done[$];
  y_wr_t mon_e;
  int    mon_c;

  logic [7:0] wmem [256];
  logic [7:0] xmem [256];

`ifdef RELU_EN
  localparam logic [7:0] L1N1 = 8'h00;
  localparam logic [7:0] L2N1 = 8'h00;
`else
  localparam logic [7:0] L1N1 = 8'h80;
  localparam logic [7:0] L2N1 = 8'hC0;
`endif

  layer_ram_sequencer_if bus ();

  layer_ram_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // RAM model: one-cycle read latency, writes land in activation RAM
  initial begin
    for (int a = 0; a < 256; a++) begin
      wmem[a] = 8'h00;
      xmem[a] = 8'h00;
    end
    wmem[8'h00] = 8'h10; wmem[8'h01] = 8'h08; wmem[8'h02] = 8'hF0; wmem[8'h03] = 8'h20;
    wmem[8'h10] = 8'h40; wmem[8'h11] = 8'h30; wmem[8'h12] = 8'hC0;
    wmem[8'h13] = 8'hD0; wmem[8'h14] = 8'h18; wmem[8'h15] = 8'hF8;
    wmem[8'h20] = 8'h08; wmem[8'h21] = 8'h00; wmem[8'h22] = 8'h20;
    wmem[8'h23] = 8'hF8; wmem[8'h24] = 8'h00; wmem[8'h25] = 8'h00;
    xmem[8'h80] = 8'h10; xmem[8'h81] = 8'h20;
    bus.w_data = 8'h00;
    bus.x_data = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.w_rd) bus.w_data <= wmem[bus.w_addr];
      if (bus.x_rd) bus.x_data <= xmem[bus.x_addr];
      if (bus.y_we) xmem[bus.y_addr] <= bus.y_data;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    y_wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic start_layer(input layer_t l, input int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.layer = l;
    exp_done.push_back(cyc + lat);
    @(negedge clk);
    bus.start = 1'b0;
    bus.layer = l ^ 2'd3;
  endtask

  task automatic wait_done(input string name);
    int budget = 200;
    while (!bus.done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: done=0, expected done within 200 cycles", name);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.y_we) begin
          if (exp_wr.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                     bus.y_addr, bus.y_data);
          end else begin
            mon_e = exp_wr.pop_front();
            check("write", 64'({bus.w_rd, bus.x_rd, bus.y_addr, bus.y_data}),
                  64'({2'b00, mon_e}));
          end
        end
        if (bus.done) begin
          if (exp_done.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
          end else begin
            mon_c = exp_done.pop_front();
            check("done_cycle", 64'(cyc), 64'(mon_c));
          end
        end
      end
    end
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.layer = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.done, bus.busy, bus.w_rd, bus.x_rd, bus.y_we,
                                bus.w_addr, bus.x_addr, bus.y_addr, bus.y_data}), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Layer 0: y = {2.0, 3.0}
    push_wr(8'h90, 8'h20);
    push_wr(8'h91, 8'h30);
    start_layer(2'd0, 9);
    check("l0_first_read", 64'({bus.busy, bus.w_rd, bus.x_rd, bus.w_addr, bus.x_addr}),
          64'({3'b111, 8'h00, 8'h80}));
    wait_done("l0");

    // Layer 1 back-to-back: positive/negative saturation and an in-range result
    push_wr(8'hA0, 8'h7F);
    push_wr(8'hA1, L1N1);
    push_wr(8'hA2, 8'h18);
    start_layer(2'd1, 13);
    check("l1_first_read", 64'({bus.w_rd, bus.w_addr, bus.x_addr}), 64'({1'b1, 8'h10, 8'h90}));
    wait_done("l1");

    // Layer 2 with a stray start mid-run; arithmetic shift floors negatives
    push_wr(8'hB0, 8'h6F);
    push_wr(8'hB1, L2N1);
    start_layer(2'd2, 11);
    check("l2_first_read", 64'({bus.w_rd, bus.w_addr, bus.x_addr}), 64'({1'b1, 8'h20, 8'hA0}));
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.layer = 2'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("l2");
    repeat (12) @(negedge clk);
    check("l2_writes_drained", 64'(exp_wr.size()), 64'(0));
    check("l2_single_done", 64'(exp_done.size()), 64'(0));

    // Layer 3 is empty: done after one cycle, busy for one cycle, no reads
    start_layer(2'd3, 1);
    wait_done("l3");
    check("l3_busy_in_fin", 64'({bus.busy, bus.w_rd, bus.x_rd}), 64'(3'b100));
    @(negedge clk);
    check("l3_busy_after", 64'({bus.busy, bus.done}), 64'(0));

    // Abort in FETCH of neuron 1 of layer 0
    push_wr(8'h90, 8'h20);
    start_layer(2'd0, 9);
    repeat (4) @(negedge clk);
    check("abort_fetch_n1", 64'({bus.w_rd, bus.w_addr, bus.x_addr}), 64'({1'b1, 8'h02, 8'h80}));
    reset = 1'b0;
    #1;
    check("abort_outputs", 64'({bus.done, bus.busy, bus.w_rd, bus.x_rd, bus.y_we,
                                bus.w_addr, bus.x_addr, bus.y_addr, bus.y_data}), 64'(0));
    check("abort_n0_written", 64'(exp_wr.size()), 64'(0));
    exp_done.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_abort_idle", 64'({bus.busy, bus.done, bus.y_we}), 64'(0));

    // Fresh run after the abort
    push_wr(8'h90, 8'h20);
    push_wr(8'h91, 8'h30);
    start_layer(2'd0, 9);
    wait_done("l0_rerun");

    repeat (4) @(negedge clk);
    check("final_writes_drained", 64'(exp_wr.size()), 64'(0));
    check("final_done_drained", 64'(exp_done.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
